// File: rtl/reset_request_watchdog.sv
// Watchdog that raises a one-cycle reset request on timeout and follows the generated reset to completion.
// Define WDT_WINDOW_EN to build the windowed variant, where a kick below WINDOW_OPEN is a violation.
module reset_request_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned ACK_TIMEOUT    = 8,
    parameter int unsigned WINDOW_OPEN    = 250,
    localparam int unsigned CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic             kick_i,
    input  logic             rst_n_generated_i,
    output logic             trigger_o,
    output logic             busy_o,
    output logic             ack_error_o,
    output logic [7:0]       expire_cnt_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned      ACK_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    if (TIMEOUT_CYCLES < 2 || ACK_TIMEOUT < 1 || WINDOW_OPEN >= TIMEOUT_CYCLES) begin : g_param_check
        $error("reset_request_watchdog: invalid parameter combination");
    end

    typedef enum logic [2:0] {
        DISABLED,
        COUNTING,
        REQUEST,
        WAIT_ASSERT,
        WAIT_RELEASE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
    logic             ack_error_q, ack_error_d;
    logic [7:0]       expire_q, expire_d;
    logic             trigger_q;
    logic             kick_violation;

`ifdef WDT_WINDOW_EN
    localparam logic [CNT_W-1:0] WIN_OPEN = CNT_W'(WINDOW_OPEN);
    assign kick_violation = kick_i && (count_q < WIN_OPEN);
`else
    assign kick_violation = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ack_cnt_d   = ack_cnt_q;
        ack_error_d = ack_error_q;
        expire_d    = expire_q;
        case (state_q)
            DISABLED: begin
                count_d = '0;
                if (enable_i) state_d = COUNTING;
            end
            COUNTING: begin
                // A kick on the last count still restarts; disable has top priority.
                if (!enable_i) begin
                    state_d = DISABLED;
                    count_d = '0;
                end else if (kick_violation) begin
                    state_d = REQUEST;
                end else if (kick_i) begin
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = REQUEST;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            REQUEST: begin
                ack_cnt_d = '0;
                state_d   = WAIT_ASSERT;
            end
            WAIT_ASSERT: begin
                if (!rst_n_generated_i) begin
                    state_d = WAIT_RELEASE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    ack_error_d = 1'b1;
                    state_d     = REQUEST;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (rst_n_generated_i) begin
                    count_d = '0;
                    state_d = enable_i ? COUNTING : DISABLED;
                    if (expire_q != 8'hFF) expire_d = expire_q + 8'd1;
                end
            end
            default: state_d = DISABLED;
        endcase
    end

    // trigger is registered from the next state so it is high exactly during REQUEST.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= DISABLED;
            count_q     <= '0;
            ack_cnt_q   <= '0;
            ack_error_q <= 1'b0;
            expire_q    <= 8'd0;
            trigger_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ack_cnt_q   <= ack_cnt_d;
            ack_error_q <= ack_error_d;
            expire_q    <= expire_d;
            trigger_q   <= (state_d == REQUEST);
        end
    end

    assign trigger_o    = trigger_q;
    assign busy_o       = (state_q == REQUEST) || (state_q == WAIT_ASSERT) || (state_q == WAIT_RELEASE);
    assign ack_error_o  = ack_error_q;
    assign expire_cnt_o = expire_q;
    assign count_o      = count_q;

endmodule
